// File: rtl/srl_pkg.sv
// Shared definitions for the serial-port responder: register map, STATUS layout,
// UART FSM states and the reset divider.
package srl_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_DIV_LO = 3'd3;
    localparam logic [2:0] ADDR_DIV_HI = 3'd4;

    localparam int unsigned ST_RX_AVAIL    = 0;
    localparam int unsigned ST_TX_NOT_FULL = 1;
    localparam int unsigned ST_RX_OVR      = 2;
    localparam int unsigned ST_FRAME_ERR   = 3;
    localparam int unsigned ST_TX_IDLE     = 4;
    localparam int unsigned ST_TX_OVF      = 5;

    localparam logic [15:0] DIV_RESET_DEFAULT = 16'd103;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uartState_t;

endpackage

// File: rtl/srl_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; a pop on a full FIFO frees
// the slot for a push on the same clock.
module srl_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wrPtr, rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush, doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdata  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/srl_port.sv
// Serial-port responder: 6502 bus register decode, TX/RX FIFOs and an 8N1 UART
// with a programmable per-bit divider.
module srl_port
    import srl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = DIV_RESET_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phi2,
    input  logic       cs_n,
    input  logic       rw,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_oe,
    output logic       irq_n,
    output logic       txd,
    input  logic       rxd
);

    logic       phi2Q, csnQ, rwQ;
    logic [2:0] addrQ;
    logic [7:0] dinQ;
    logic       commit, wrCommit, statusClr, baudClr;

    logic [15:0] div;
    logic [1:0]  ctrl;
    logic        rxOvr, frameErr, txOvf, irqQ;
    logic        rxOvrSet, frameErrSet, txOvfSet;

    logic       txPush, txPop, txFull, txEmpty, txIdle;
    logic [7:0] txHead;
    logic       rxPush, rxPop, rxFull, rxEmpty;
    logic [7:0] rxHead;

    uartState_t  txState, txStateD;
    logic [15:0] txCnt, txCntD;
    logic [2:0]  txBit, txBitD;
    logic [7:0]  txShift, txShiftD;
    logic        txdQ, txdD, txTick;

    uartState_t  rxState, rxStateD;
    logic [15:0] rxCnt, rxCntD;
    logic [2:0]  rxBit, rxBitD;
    logic [7:0]  rxShift, rxShiftD;
    logic        rxS1, rxS2, rxPrev, rxTick, rxHalf;

    logic [7:0] status, rdVal;

    // Bus strobes are sampled so side effects land once, just after phi2 falls.
    assign commit    = !phi2 && phi2Q && !csnQ;
    assign wrCommit  = commit && !rwQ;
    assign statusClr = wrCommit && (addrQ == ADDR_STATUS);
    assign baudClr   = wrCommit && (addrQ == ADDR_DIV_HI);
    assign txPush    = wrCommit && (addrQ == ADDR_DATA);
    assign rxPop     = commit && rwQ && (addrQ == ADDR_DATA);
    assign txOvfSet  = txPush && txFull && !txPop;
    assign txIdle    = (txState == StIdle) && txEmpty;

    always_comb begin
        status                 = '0;
        status[ST_RX_AVAIL]    = !rxEmpty;
        status[ST_TX_NOT_FULL] = !txFull;
        status[ST_RX_OVR]      = rxOvr;
        status[ST_FRAME_ERR]   = frameErr;
        status[ST_TX_IDLE]     = txIdle;
        status[ST_TX_OVF]      = txOvf;
    end

    always_comb begin
        rdVal = 8'h00;
        case (addr)
            ADDR_DATA:   rdVal = rxEmpty ? 8'h00 : rxHead;
            ADDR_STATUS: rdVal = status;
            ADDR_CTRL:   rdVal = {6'b0, ctrl};
            ADDR_DIV_LO: rdVal = div[7:0];
            ADDR_DIV_HI: rdVal = div[15:8];
            default:     rdVal = 8'h00;
        endcase
    end

    assign dout    = cs_n ? 8'h00 : rdVal;
    assign dout_oe = !cs_n && rw;
    assign irq_n   = irqQ;
    assign txd     = txdQ;

    always_ff @(posedge clk) begin
        if (!rst) begin
            phi2Q <= 1'b0;
            csnQ  <= 1'b1;
            rwQ   <= 1'b1;
            addrQ <= '0;
            dinQ  <= '0;
        end else begin
            phi2Q <= phi2;
            csnQ  <= cs_n;
            rwQ   <= rw;
            addrQ <= addr;
            dinQ  <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div      <= DIV_RESET;
            ctrl     <= '0;
            rxOvr    <= 1'b0;
            frameErr <= 1'b0;
            txOvf    <= 1'b0;
            irqQ     <= 1'b1;
        end else begin
            if (wrCommit) begin
                case (addrQ)
                    ADDR_CTRL:   ctrl      <= dinQ[1:0];
                    ADDR_DIV_LO: div[7:0]  <= dinQ;
                    ADDR_DIV_HI: div[15:8] <= dinQ;
                    default:     ;
                endcase
            end
            // A fresh error outranks a simultaneous clear.
            rxOvr    <= (rxOvr && !statusClr) || rxOvrSet;
            frameErr <= (frameErr && !statusClr) || frameErrSet;
            txOvf    <= (txOvf && !statusClr) || txOvfSet;
            irqQ     <= !((ctrl[0] && !rxEmpty) || (ctrl[1] && txIdle));
        end
    end

    srl_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) uTxFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (txPush),
        .pop   (txPop),
        .wdata (dinQ),
        .rdata (txHead),
        .full  (txFull),
        .empty (txEmpty)
    );

    srl_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) uRxFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rxPush),
        .pop   (rxPop),
        .wdata (rxShift),
        .rdata (rxHead),
        .full  (rxFull),
        .empty (rxEmpty)
    );

    // Transmitter
    assign txTick = (txCnt >= div);

    always_ff @(posedge clk) begin
        if (!rst) begin
            txState <= StIdle;
            txCnt   <= '0;
            txBit   <= '0;
            txShift <= '0;
            txdQ    <= 1'b1;
        end else begin
            txState <= txStateD;
            txCnt   <= txCntD;
            txBit   <= txBitD;
            txShift <= txShiftD;
            txdQ    <= txdD;
        end
    end

    always_comb begin
        txStateD = txState;
        txCntD   = txCnt;
        txBitD   = txBit;
        txShiftD = txShift;
        case (txState)
            StIdle: begin
                if (!txEmpty) begin
                    txStateD = StStart;
                    txShiftD = txHead;
                    txCntD   = '0;
                end
            end
            StStart: begin
                if (txTick) begin
                    txStateD = StData;
                    txCntD   = '0;
                    txBitD   = '0;
                end else begin
                    txCntD = txCnt + 16'd1;
                end
            end
            StData: begin
                if (txTick) begin
                    txCntD   = '0;
                    txShiftD = {1'b0, txShift[7:1]};
                    if (txBit == 3'd7) txStateD = StStop;
                    else               txBitD   = txBit + 3'd1;
                end else begin
                    txCntD = txCnt + 16'd1;
                end
            end
            StStop: begin
                if (txTick) begin
                    txStateD = StIdle;
                    txCntD   = '0;
                end else begin
                    txCntD = txCnt + 16'd1;
                end
            end
            default: txStateD = StIdle;
        endcase
        if (baudClr) txCntD = '0;
    end

    always_comb begin
        txPop = (txState == StIdle) && !txEmpty;
        case (txStateD)
            StStart: txdD = 1'b0;
            StData:  txdD = txShiftD[0];
            default: txdD = 1'b1;
        endcase
    end

    // Receiver
    assign rxTick = (rxCnt >= div);
    assign rxHalf = ({1'b0, rxCnt} + 17'd1) >= (({1'b0, div} + 17'd1) >> 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rxS1    <= 1'b1;
            rxS2    <= 1'b1;
            rxPrev  <= 1'b1;
            rxState <= StIdle;
            rxCnt   <= '0;
            rxBit   <= '0;
            rxShift <= '0;
        end else begin
            rxS1    <= rxd;
            rxS2    <= rxS1;
            rxPrev  <= rxS2;
            rxState <= rxStateD;
            rxCnt   <= rxCntD;
            rxBit   <= rxBitD;
            rxShift <= rxShiftD;
        end
    end

    always_comb begin
        rxStateD = rxState;
        rxCntD   = rxCnt;
        rxBitD   = rxBit;
        rxShiftD = rxShift;
        case (rxState)
            StIdle: begin
                if (rxPrev && !rxS2) begin
                    rxStateD = StStart;
                    rxCntD   = '0;
                end
            end
            StStart: begin
                if (rxHalf) begin
                    rxCntD   = '0;
                    rxBitD   = '0;
                    rxStateD = rxS2 ? StIdle : StData;
                end else begin
                    rxCntD = rxCnt + 16'd1;
                end
            end
            StData: begin
                if (rxTick) begin
                    rxCntD   = '0;
                    rxShiftD = {rxS2, rxShift[7:1]};
                    if (rxBit == 3'd7) rxStateD = StStop;
                    else               rxBitD   = rxBit + 3'd1;
                end else begin
                    rxCntD = rxCnt + 16'd1;
                end
            end
            StStop: begin
                if (rxTick) begin
                    rxStateD = StIdle;
                    rxCntD   = '0;
                end else begin
                    rxCntD = rxCnt + 16'd1;
                end
            end
            default: rxStateD = StIdle;
        endcase
        if (baudClr) rxCntD = '0;
    end

    // A CPU pop on the same clock makes room, so a full FIFO is not an overrun then.
    always_comb begin
        rxPush      = 1'b0;
        frameErrSet = 1'b0;
        rxOvrSet    = 1'b0;
        if (rxState == StStop && rxTick) begin
            if (!rxS2)                 frameErrSet = 1'b1;
            else if (rxFull && !rxPop) rxOvrSet    = 1'b1;
            else                       rxPush      = 1'b1;
        end
    end

endmodule

// File: doc/srl_port.md
# srl_port

Serial-port responder on the 6502 bus: the peripheral that answers the glue logic's serial chip select in the 0x9F60–0x9F6F I/O window. It decodes CPU register reads and writes, buffers bytes in small TX/RX FIFOs, and runs an 8N1 UART with a programmable bit divider. It raises an open-drain-style interrupt request toward the CPU. It runs on the same master clock as the glue logic, so the bus strobes arrive synchronous to `clk`.

## Interface
Parameters:
- FIFO_DEPTH, 4: entries per FIFO; must be a power of two, at least 2.
- DIV_RESET, 16'd103: divider value loaded at reset.

Ports:
- clk  in  1  master clock, same as the glue logic's `clk`
- rst  in  1  reset; synchronous, active-low
- phi2  in  1  CPU system clock, synchronous to `clk`
- cs_n  in  1  serial chip select; already qualified with phi2 high
- rw  in  1  1 = read, 0 = write
- addr  in  3  `adrBusLo[2:0]`
- din  in  8  CPU data bus in
- dout  out  8  read data
- dout_oe  out  1  drive enable for `dout`
- irq_n  out  1  active-low interrupt request
- txd  out  1  serial transmit, idle high
- rxd  in  1  serial receive, asynchronous

## Operation
- Bus access:
  - `dout_oe` = !cs_n && rw.
  - `dout` is combinational from `addr` while selected.
  - A commit happens on the first `clk` where phi2 is 0 and the registered phi2 is 1, with the registered cs_n = 0.
  - Write side effects and RX pops occur only at commit.
- Register map:
  - 0 DATA. Write pushes to the TX FIFO; if full, the byte is dropped and `tx_ovf` is set. Read returns the RX head; the commit pops it. Reading an empty FIFO returns 0x00 and changes nothing.
  - 1 STATUS (read): [0] rx_avail, [1] tx_not_full, [2] rx_ovr, [3] frame_err, [4] tx_idle, [5] tx_ovf. Writing any value clears bits 2, 3 and 5.
  - 2 CTRL (r/w, reset 0x00): [0] rx_ie, [1] tx_ie.
  - 3 DIV_LO and 4 DIV_HI (r/w). A write to DIV_HI also resets both baud counters.
  - 5–7: read 0x00, writes ignored.
- Interrupt: irq_n = !((rx_ie && rx_avail) || (tx_ie && tx_idle)).
- Transmitter:
  - States IDLE → START → DATA(8, LSB first) → STOP → IDLE. Each bit lasts DIV+1 clocks.
  - Leaves IDLE the clock after the FIFO is non-empty, popping at that transition.
  - tx_idle = IDLE && TX FIFO empty.
- Receiver:
  - Input path: 2-flop synchronizer on `rxd`.
  - States IDLE → START → DATA → STOP.
  - IDLE sees a synchronized falling edge, waits (DIV+1)/2 clocks, and rechecks low. If not low it is a glitch: return to IDLE.
  - Data and stop bits are sampled every DIV+1 clocks thereafter.
  - Stop bit = 0: set frame_err, discard the byte.
  - Stop bit valid with the RX FIFO full: set rx_ovr, discard the byte.
  - Otherwise push the byte.
- Width rules:
  - DIV is 16 bits; DIV=0 gives 1 clock per bit.
  - FIFO pointers are log2(DEPTH)+1 bits. full = MSBs differ and LSBs are equal.
- Simultaneous events:
  - A CPU push and a transmitter pop on the same clock on a full FIFO: the pop is taken first, so the push succeeds.
  - A receiver push and a CPU pop on a full RX FIFO: both happen, and no overrun is flagged.
  - A STATUS clear coinciding with a new error: the error wins.
- Reset (asserted mid-frame): the next clock forces txd=1, both FSMs IDLE, FIFOs empty, flags 0, CTRL 0, DIV=DIV_RESET, irq_n=1, dout_oe per cs_n.

## Timing
- Commit occurs 1 clk after the phi2 falling edge. A CPU cycle produces exactly one commit, including stretched cycles.
- A DATA write reaches the txd start bit 2 clk after commit when the TX side is idle.
- RX latency: the byte is visible to STATUS/DATA 1 clk after the stop-bit sample.
- Frame length is 10×(DIV+1) clk.
- All outputs except `dout`/`dout_oe` are registered.

## Structure
- Package `srl_pkg`: register address constants, STATUS bit indices, FSM state enum, DIV_RESET default.
- Sub-module `srl_fifo` (parameterized depth/width, push/pop/full/empty, same-cycle push+pop), instantiated twice.
- The top holds the bus decode, TX FSM, RX FSM and baud counters.

## Test plan
- Reset, then read STATUS → 0x12 (tx_not_full, tx_idle); irq_n=1; txd=1.
- DIV=0x0003, write DATA=0xA5 → txd waveform 0,1,0,1,0,0,1,0,1,1 at 4 clk per bit, 40 clk total; tx_idle returns to 1.
- Write 5 bytes quickly with DEPTH=4 and txd stalled by a large DIV → one byte is accepted once the transmitter pops. Variant with the transmitter not yet popped: 5th byte dropped, STATUS[5]=1; writing STATUS clears it.
- Drive 0x3C on rxd at DIV=3 → rx_avail=1; DATA read returns 0x3C; a second read returns 0x00.
- Send 5 RX bytes with no reads → rx_ovr=1, FIFO holds the first 4. Stop bit forced low → frame_err=1, no push.
- Assert rst halfway through a TX frame → txd=1 next clk; FIFOs empty; rx_ie=1 with an RX byte pending before reset gives irq_n=1 after reset.
